// File: rtl/pe_row_sched_pkg.sv
// pe_row_sched_pkg: shared widths, job limits and controller states for the PE row scheduler
package pe_row_sched_pkg;
  localparam int WIDTH = 8;
  localparam int LEN_W = 8;
  localparam int ROW_LAT = 8;
  localparam int K_MAX = 255;
  typedef enum logic [2:0] {IDLE, CLR, FEED, DRAIN, OUT} sched_state_e;
endpackage

// File: rtl/pe_row_sched.sv
// pe_row_sched: job controller that feeds one 8-PE systolic row and returns its partial sum
module pe_row_sched #(
  parameter int LEN_W = pe_row_sched_pkg::LEN_W,
  parameter int ROW_LAT = pe_row_sched_pkg::ROW_LAT,
  parameter int K_MAX = pe_row_sched_pkg::K_MAX
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                i_start,
  input  logic [LEN_W-1:0]                    i_len,
  output logic                                o_busy,
  input  logic                                i_op_valid,
  output logic                                o_op_ready,
  input  logic [pe_row_sched_pkg::WIDTH-1:0]   i_op_r,
  input  logic [pe_row_sched_pkg::WIDTH-1:0]   i_op_f,
  output logic                                o_row_en,
  output logic                                o_row_clr,
  output logic [pe_row_sched_pkg::WIDTH-1:0]   o_row_r,
  output logic [pe_row_sched_pkg::WIDTH-1:0]   o_row_f,
  input  logic [2*pe_row_sched_pkg::WIDTH-1:0] i_row_psum,
  output logic                                o_res_valid,
  input  logic                                i_res_ready,
  output logic [2*pe_row_sched_pkg::WIDTH-1:0] o_res_data
);
  import pe_row_sched_pkg::*;
  localparam int DW = $clog2(ROW_LAT + 1);
  sched_state_e state;
  logic [LEN_W-1:0] len_q, cnt, len_sat;
  logic [DW-1:0] drain_cnt;
  logic accept;
  assign len_sat = (i_len > LEN_W'(K_MAX)) ? LEN_W'(K_MAX) : i_len;
  assign o_op_ready = (state == FEED) && (cnt != len_q);
  assign accept = i_op_valid && o_op_ready;
  // The first DRAIN cycle still shows the last pair; ROW_LAT zero cycles follow before capture.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      len_q <= '0;
      cnt <= '0;
      drain_cnt <= '0;
      o_busy <= 1'b0;
      o_row_en <= 1'b0;
      o_row_clr <= 1'b0;
      o_row_r <= '0;
      o_row_f <= '0;
      o_res_valid <= 1'b0;
      o_res_data <= '0;
    end else begin
      case (state)
        IDLE: if (i_start) begin
          len_q <= len_sat;
          cnt <= '0;
          drain_cnt <= '0;
          o_busy <= 1'b1;
          o_res_data <= '0;
          o_row_clr <= len_sat != '0;
          o_res_valid <= len_sat == '0;
          state <= (len_sat == '0) ? OUT : CLR;
        end
        CLR: begin
          o_row_clr <= 1'b0;
          state <= FEED;
        end
        FEED: begin
          o_row_en <= accept;
          if (accept) begin
            o_row_r <= i_op_r;
            o_row_f <= i_op_f;
            cnt <= cnt + 1'b1;
            if ((cnt + 1'b1) == len_q) state <= DRAIN;
          end
        end
        DRAIN: if (drain_cnt == DW'(ROW_LAT)) begin
          o_row_en <= 1'b0;
          o_res_data <= i_row_psum;
          o_res_valid <= 1'b1;
          state <= OUT;
        end else begin
          o_row_en <= 1'b1;
          o_row_r <= '0;
          o_row_f <= '0;
          drain_cnt <= drain_cnt + 1'b1;
        end
        OUT: if (i_res_ready) begin
          o_res_valid <= 1'b0;
          o_busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pe_row_sched.sv
// tb_pe_row_sched: directed scenarios against a behavioural 8-stage PE row model
module tb_pe_row_sched;
  import pe_row_sched_pkg::*;
  localparam int LW = 9;
  logic clk = 1'b0, rstn = 1'b0, i_start = 1'b0, i_op_valid = 1'b0, i_res_ready = 1'b0;
  logic [LW-1:0] i_len = '0;
  logic [WIDTH-1:0] i_op_r = '0, i_op_f = '0, o_row_r, o_row_f;
  logic [2*WIDTH-1:0] row_psum, o_res_data, acc;
  logic [2*WIDTH-1:0] pipe [ROW_LAT-1];
  logic o_busy, o_op_ready, o_row_en, o_row_clr, o_res_valid;
  int vecs = 0, errs = 0;
  int pr[300], pf[300];
  int lat, en_cnt, clr_cnt, consumed;
  bit refused;

  always #5 clk = ~clk;

  pe_row_sched #(.LEN_W(LW), .ROW_LAT(ROW_LAT), .K_MAX(K_MAX)) dut (
    .clk(clk), .rstn(rstn), .i_start(i_start), .i_len(i_len), .o_busy(o_busy),
    .i_op_valid(i_op_valid), .o_op_ready(o_op_ready), .i_op_r(i_op_r), .i_op_f(i_op_f),
    .o_row_en(o_row_en), .o_row_clr(o_row_clr), .o_row_r(o_row_r), .o_row_f(o_row_f),
    .i_row_psum(row_psum), .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
    .o_res_data(o_res_data)
  );

  // Row model: a product enters on an enabled edge and lands in the sum ROW_LAT enabled edges later.
  always @(posedge clk or negedge rstn) begin
    if (!rstn || o_row_clr) begin
      acc <= '0;
      for (int i = 0; i < ROW_LAT - 1; i++) pipe[i] <= '0;
    end else if (o_row_en) begin
      acc <= acc + pipe[ROW_LAT-2];
      pipe[0] <= (2*WIDTH)'(o_row_r) * (2*WIDTH)'(o_row_f);
      for (int i = 1; i < ROW_LAT - 1; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign row_psum = acc;

  task automatic do_job(input int len, input int avail, input int gap_at, input int gap_n, input int abort_at);
    int gaps;
    bit hs;
    gaps = 0;
    @(negedge clk);
    i_start = 1'b1;
    i_len = LW'(len);
    @(posedge clk);
    #1;
    i_start = 1'b0;
    lat = 0; en_cnt = 0; clr_cnt = 0; consumed = 0; refused = 0;
    while (lat < 2000) begin
      if (o_row_clr) clr_cnt++;
      if (o_row_en) en_cnt++;
      if (o_res_valid || consumed == abort_at) break;
      if (consumed == gap_at && gaps < gap_n) begin
        i_op_valid = 1'b0;
        gaps++;
      end else i_op_valid = consumed < avail;
      i_op_r = WIDTH'(pr[consumed]);
      i_op_f = WIDTH'(pf[consumed]);
      #1;
      hs = i_op_valid && o_op_ready;
      if (consumed == 255 && i_op_valid && !o_op_ready) refused = 1;
      @(posedge clk);
      #1;
      if (hs) consumed++;
      lat++;
    end
    i_op_valid = 1'b0;
    if (lat >= 2000) begin
      vecs++; errs++;
      $display("FAIL job_timeout len=%0d no result after %0d cycles", len, lat);
    end
  endtask

  task automatic take_result();
    @(negedge clk);
    i_res_ready = 1'b1;
    @(posedge clk);
    #1;
    i_res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vecs++;
    if ({o_busy, o_res_valid, o_row_en, o_row_clr, o_op_ready} !== 5'b0) begin
      errs++; $display("FAIL reset_ctrl got %b want 00000", {o_busy, o_res_valid, o_row_en, o_row_clr, o_op_ready});
    end
    vecs++;
    if ({o_res_data, o_row_r, o_row_f} !== '0) begin
      errs++; $display("FAIL reset_data got %h/%h/%h want 0", o_res_data, o_row_r, o_row_f);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_basic();
    pr[0] = 1; pr[1] = 2; pr[2] = 3;
    pf[0] = 1; pf[1] = 2; pf[2] = 3;
    do_job(3, 3, -1, 0, -1);
    vecs++; if (lat !== 13) begin errs++; $display("FAIL basic_latency got %0d want 13", lat); end
    vecs++; if (clr_cnt !== 1) begin errs++; $display("FAIL basic_clr_pulses got %0d want 1", clr_cnt); end
    vecs++; if (en_cnt !== 11) begin errs++; $display("FAIL basic_en_cycles got %0d want 11", en_cnt); end
    vecs++; if (o_res_data !== 16'd14) begin errs++; $display("FAIL basic_result got %0d want 14", o_res_data); end
    vecs++; if (consumed !== 3) begin errs++; $display("FAIL basic_consumed got %0d want 3", consumed); end
    take_result();
    vecs++;
    if ({o_res_valid, o_busy} !== 2'b00) begin
      errs++; $display("FAIL basic_release got valid/busy %b want 00", {o_res_valid, o_busy});
    end
  endtask

  task automatic test_stall();
    do_job(3, 3, 1, 2, -1);
    vecs++; if (lat !== 15) begin errs++; $display("FAIL stall_latency got %0d want 15", lat); end
    vecs++; if (en_cnt !== 11) begin errs++; $display("FAIL stall_en_cycles got %0d want 11", en_cnt); end
    vecs++; if (o_res_data !== 16'd14) begin errs++; $display("FAIL stall_result got %0d want 14", o_res_data); end
    take_result();
  endtask

  task automatic test_zero_len();
    do_job(0, 0, -1, 0, -1);
    vecs++; if (lat !== 0) begin errs++; $display("FAIL zero_latency got %0d want 0", lat); end
    vecs++; if (o_res_valid !== 1'b1) begin errs++; $display("FAIL zero_valid got %b want 1", o_res_valid); end
    vecs++; if (o_res_data !== 16'd0) begin errs++; $display("FAIL zero_result got %0d want 0", o_res_data); end
    vecs++;
    if (en_cnt !== 0 || clr_cnt !== 0 || o_row_en !== 1'b0) begin
      errs++; $display("FAIL zero_row_idle got en=%0d clr=%0d want 0/0", en_cnt, clr_cnt);
    end
    take_result();
    vecs++; if (o_busy !== 1'b0) begin errs++; $display("FAIL zero_release got busy=%b want 0", o_busy); end
  endtask

  task automatic test_back_pressure();
    pr[0] = 1; pr[1] = 2; pr[2] = 3;
    pf[0] = 1; pf[1] = 2; pf[2] = 3;
    do_job(3, 3, -1, 0, -1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      i_start = 1'b1;
      i_len = LW'(2);
      @(posedge clk);
      #1;
      vecs++;
      if (o_res_valid !== 1'b1 || o_res_data !== 16'd14 || o_busy !== 1'b1) begin
        errs++; $display("FAIL hold_cycle%0d got valid=%b data=%0d busy=%b want 1/14/1", c, o_res_valid, o_res_data, o_busy);
      end
    end
    @(negedge clk);
    i_start = 1'b0;
    i_res_ready = 1'b1;
    @(posedge clk);
    #1;
    i_res_ready = 1'b0;
    vecs++;
    if ({o_res_valid, o_busy} !== 2'b00) begin
      errs++; $display("FAIL hold_release got valid/busy %b want 00", {o_res_valid, o_busy});
    end
    @(posedge clk);
    #1;
    vecs++; if (o_busy !== 1'b0) begin errs++; $display("FAIL hold_no_queue got busy=%b want 0", o_busy); end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 4; i++) begin pr[i] = 9; pf[i] = 9; end
    do_job(4, 4, -1, 0, 2);
    #3;
    rstn = 1'b0;
    #1;
    vecs++;
    if ({o_busy, o_res_valid, o_row_en, o_row_clr, o_op_ready} !== 5'b0 || o_row_r !== '0 || o_row_f !== '0) begin
      errs++; $display("FAIL abort_outputs got ctrl=%b r=%0d f=%0d want 0", {o_busy, o_res_valid, o_row_en, o_row_clr, o_op_ready}, o_row_r, o_row_f);
    end
    @(negedge clk);
    rstn = 1'b1;
    pr[0] = 4; pf[0] = 5; pr[1] = 1; pf[1] = 1;
    do_job(2, 2, -1, 0, -1);
    vecs++; if (o_res_data !== 16'd21) begin errs++; $display("FAIL abort_next_result got %0d want 21", o_res_data); end
    vecs++; if (lat !== 12) begin errs++; $display("FAIL abort_next_latency got %0d want 12", lat); end
    take_result();
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) begin pr[i] = 1; pf[i] = 1; end
    do_job(300, 256, -1, 0, -1);
    vecs++; if (consumed !== 255) begin errs++; $display("FAIL sat_consumed got %0d want 255", consumed); end
    vecs++; if (refused !== 1'b1) begin errs++; $display("FAIL sat_extra_refused got %b want 1", refused); end
    vecs++; if (o_res_data !== 16'd255) begin errs++; $display("FAIL sat_result got %0d want 255", o_res_data); end
    vecs++; if (lat !== 265) begin errs++; $display("FAIL sat_latency got %0d want 265", lat); end
    take_result();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero_len();
    test_back_pressure();
    test_abort();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/pe_row_sched.md
Name: pe_row_sched

Overview:
- Job controller for one 8-PE systolic row (PE_ROW8).
- Accepts a dot-product job of programmable length and streams operand pairs from an upstream ready/valid source into the row.
- Drains the row pipeline with zero operands, captures the row partial sum and presents it downstream on a ready/valid result port.
- Sits between the operand buffers and one PE row in the LeViT accelerator datapath.

Parameters:
- ROW_LAT, 8, cycles from the last enabled operand pair to a settled row sum (one per PE).
- K_MAX, 255, maximum operand pairs per job.
- LEN_W, 8, width of the job-length field; must satisfy 2**LEN_W-1 >= K_MAX.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- i_start  in  1  job request; sampled only in IDLE.
- i_len  in  LEN_W  operand pairs for this job; sampled with i_start.
- o_busy  out  1  high in every state except IDLE.
- i_op_valid  in  1  operand pair valid.
- o_op_ready  out  1  controller accepts a pair this cycle.
- i_op_r  in  width  row operand.
- i_op_f  in  width  filter operand.
- o_row_en  out  1  to PE row en.
- o_row_clr  out  1  one-cycle accumulator clear to the PE row (gated with rstn at top level).
- o_row_r  out  width  to PE row i_r.
- o_row_f  out  width  to PE row i_f.
- i_row_psum  in  2*width  from PE row o_psum.
- o_res_valid  out  1  result valid.
- i_res_ready  in  1  downstream accepts result.
- o_res_data  out  2*width  captured partial sum.

Behaviour:
- Reset (async, rstn=0): state IDLE; all outputs 0; pair counter, drain counter and result register cleared. A reset asserted mid-job aborts the job with no result emitted.
- All outputs are registered except o_op_ready, which is combinational: (state==FEED) && (cnt != len).
- IDLE -> CLR when i_start=1 and i_len!=0. Latch len.
- IDLE -> OUT when i_start=1 and i_len==0. Result is 0; the row is never enabled.
- i_len > K_MAX is saturated to K_MAX.
- CLR: lasts exactly 1 cycle with o_row_clr=1 and o_row_en=0, then go to FEED.
- FEED:
  - A pair is accepted on the cycle where i_op_valid && o_op_ready. The next cycle drives o_row_r/o_row_f = the accepted pair and o_row_en=1.
  - Cycles with no accepted pair drive o_row_en=0, freezing the row; operand registers hold their values.
  - cnt increments per accepted pair. After the cycle that registers pair len, go to DRAIN.
- DRAIN:
  - o_row_en=1 and o_row_r=o_row_f=0 for exactly ROW_LAT cycles.
  - On the last DRAIN cycle, o_res_data <= i_row_psum. Next state is OUT.
- OUT:
  - o_res_valid=1 and o_res_en=0; o_res_data is held stable until i_res_ready=1.
  - On the handshake cycle, o_res_valid drops next cycle and the state returns to IDLE.
- i_start outside IDLE is ignored. There is no queued job.
- No arithmetic overflow handling: o_res_data is the row's 2*width value verbatim.
- Minimum job latency: i_start to o_res_valid = 1 (CLR) + len + 1 + ROW_LAT cycles, with i_op_valid held high.
- Job-length accounting: exactly len pairs are consumed per job. A pair presented after the job's last accepted pair is left unconsumed (o_op_ready=0).

Decomposition:
- Package definition: width (existing); add LEN_W, ROW_LAT, K_MAX; add typedef enum logic [2:0] sched_state_e {IDLE, CLR, FEED, DRAIN, OUT}.
- Sub-modules: none required. The drain counter could be split out as a generic down-counter, but inline is preferred at this size.

Test Plan:
- len=3, pairs (1,1),(2,2),(3,3) with i_op_valid always high, PE row connected -> o_row_clr pulses once; o_res_data=14; o_res_valid rises 1+3+1+8=13 cycles after i_start.
- Same job with i_op_valid low for 2 cycles between pairs 1 and 2 -> o_row_en low exactly those 2 cycles; result still 14; latency +2.
- len=0 -> o_res_valid next cycle with o_res_data=0; o_row_en never asserted.
- Result back-pressure: i_res_ready held low 5 cycles -> o_res_valid and o_res_data=14 stable; i_start pulses during OUT ignored; IDLE one cycle after ready.
- rstn dropped mid-FEED after 2 of 4 pairs -> outputs 0 immediately; new job len=2, (4,5),(1,1) -> result 21 (no residue from the aborted job).
- i_len=300 with LEN_W=9, K_MAX=255 -> exactly 255 pairs consumed; the 256th presented pair sees o_op_ready=0.
